// File: rtl/spi_device_shift_register.sv
// SPI device shift register: mode 0, Standard/Dual/Quad lanes.
// Byte-wide TX/RX streams with overflow/underflow/deassert events.
module spi_device_shift_register #(
   parameter logic [7:0] TxIdleByte = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sw_rst_i,
   input  logic [1:0] speed_i,
   input  logic       dir_i,
   input  logic       sclk_i,
   input  logic       csb_i,
   input  logic [3:0] sd_i,
   output logic [3:0] sd_o,
   output logic [3:0] sd_en_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_first_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       rx_overflow_o,
   output logic       tx_underflow_o,
   output logic       csb_deassert_o
);

   logic       srst;
   logic       sclk_q;
   logic       csb_q;
   logic       armed_q;
   logic       active_q;
   logic       first_q;
   logic [1:0] spd_q;
   logic [2:0] cnt;
   logic [7:0] rx_sr;
   logic [7:0] tx_sr;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       rx_first_q;
   logic       ovf_q;
   logic       und_q;
   logic       dea_q;

   logic       csb_fall;
   logic       csb_rise;
   logic       rise;
   logic       fall;
   logic       run;
   logic [3:0] bpe;
   logic [3:0] cnt_sum;
   logic       byte_done;
   logic [7:0] rx_next;
   logic [7:0] tx_shift;
   logic       tx_load;
   logic       consume;
   logic       rx_load;
   logic       overflow;

   assign srst = rst_i | sw_rst_i;

   // armed_q blocks a start right after reset while csb is still held low
   assign csb_fall = armed_q & csb_q & ~csb_i;
   assign csb_rise = active_q & csb_i;
   assign rise     = active_q & ~csb_i & sclk_i & ~sclk_q;
   assign fall     = active_q & ~csb_i & ~sclk_i & sclk_q;
   assign run      = (spd_q != 2'd3);

   // lane-mode decode: bits per edge and shifted register images
   always_comb begin
      bpe      = 4'd0;
      rx_next  = rx_sr;
      tx_shift = tx_sr;
      case (spd_q)
         2'd0: begin
            bpe      = 4'd1;
            rx_next  = {rx_sr[6:0], sd_i[0]};
            tx_shift = {tx_sr[6:0], 1'b0};
         end
         2'd1: begin
            bpe      = 4'd2;
            rx_next  = {rx_sr[5:0], sd_i[1:0]};
            tx_shift = {tx_sr[5:0], 2'b00};
         end
         2'd2: begin
            bpe      = 4'd4;
            rx_next  = {rx_sr[3:0], sd_i};
            tx_shift = {tx_sr[3:0], 4'b0000};
         end
         default: ;
      endcase
   end

   assign cnt_sum   = {1'b0, cnt} + bpe;
   assign byte_done = rise & run & cnt_sum[3];
   assign tx_load   = ~srst & ((csb_fall & (speed_i != 2'd3)) |
                               (fall & run & (cnt == 3'd0)));
   assign consume   = rx_valid_q & rx_ready_i;
   assign rx_load   = byte_done & (~rx_valid_q | consume);
   assign overflow  = byte_done & ~rx_load;

   // edge detectors, transaction tracking and event pulses
   always_ff @(posedge clk_i) begin
      if (srst) begin
         sclk_q   <= 1'b0;
         csb_q    <= 1'b1;
         armed_q  <= 1'b0;
         active_q <= 1'b0;
         first_q  <= 1'b0;
         spd_q    <= 2'd0;
         cnt      <= 3'd0;
         rx_sr    <= 8'h00;
         ovf_q    <= 1'b0;
         und_q    <= 1'b0;
         dea_q    <= 1'b0;
      end else begin
         sclk_q <= sclk_i;
         csb_q  <= csb_i;
         ovf_q  <= overflow;
         und_q  <= tx_load & ~tx_valid_i;
         dea_q  <= csb_rise;
         if (csb_i) armed_q <= 1'b1;
         if (csb_fall) begin
            active_q <= 1'b1;
            spd_q    <= speed_i;
            cnt      <= 3'd0;
            first_q  <= 1'b1;
         end else if (csb_rise) begin
            active_q <= 1'b0;
            cnt      <= 3'd0;
            rx_sr    <= 8'h00;
         end else if (rise && run) begin
            cnt   <= cnt_sum[2:0];
            rx_sr <= rx_next;
            if (cnt_sum[3]) first_q <= 1'b0;
         end
      end
   end

   // TX shift register: load at byte boundaries, shift on each fall
   always_ff @(posedge clk_i) begin
      if (srst) begin
         tx_sr <= 8'h00;
      end else if (tx_load) begin
         tx_sr <= tx_valid_i ? tx_data_i : TxIdleByte;
      end else if (fall && run) begin
         tx_sr <= tx_shift;
      end
   end

   // single-entry RX buffer
   always_ff @(posedge clk_i) begin
      if (srst) begin
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_first_q <= 1'b0;
      end else if (rx_load) begin
         rx_valid_q <= 1'b1;
         rx_data_q  <= rx_next;
         rx_first_q <= first_q;
      end else if (consume) begin
         rx_valid_q <= 1'b0;
      end
   end

   // lane drivers, silent outside an active transaction
   always_comb begin
      sd_o    = 4'b0000;
      sd_en_o = 4'b0000;
      if (active_q && !csb_i) begin
         case (spd_q)
            2'd0: begin
               sd_o    = {2'b00, tx_sr[7], 1'b0};
               sd_en_o = 4'b0010;
            end
            2'd1: begin
               sd_o    = {2'b00, tx_sr[7:6]};
               sd_en_o = dir_i ? 4'b0011 : 4'b0000;
            end
            2'd2: begin
               sd_o    = tx_sr[7:4];
               sd_en_o = dir_i ? 4'b1111 : 4'b0000;
            end
            default: ;
         endcase
      end
   end

   assign tx_ready_o     = tx_load & tx_valid_i;
   assign rx_data_o      = rx_data_q;
   assign rx_first_o     = rx_first_q;
   assign rx_valid_o     = rx_valid_q;
   assign rx_overflow_o  = ovf_q;
   assign tx_underflow_o = und_q;
   assign csb_deassert_o = dea_q;

endmodule

// File: tb/tb_spi_device_shift_register.sv
// Bench for spi_device_shift_register: directed cases plus random
// transactions checked against a byte-level behavioural model.
module tb_spi_device_shift_register;

   localparam logic [7:0] IDLE = 8'hFF;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       sw_rst_i = 1'b0;
   logic [1:0] speed_i = 2'd0;
   logic       dir_i = 1'b0;
   logic       sclk_i = 1'b0;
   logic       csb_i = 1'b1;
   logic [3:0] sd_i = 4'h0;
   logic [3:0] sd_o;
   logic [3:0] sd_en_o;
   logic [7:0] tx_data_i = 8'h00;
   logic       tx_valid_i = 1'b0;
   logic       tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_first_o;
   logic       rx_valid_o;
   logic       rx_ready_i = 1'b1;
   logic       rx_overflow_o;
   logic       tx_underflow_o;
   logic       csb_deassert_o;

   always #5 clk = ~clk;

   spi_device_shift_register dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .sw_rst_i       (sw_rst_i),
      .speed_i        (speed_i),
      .dir_i          (dir_i),
      .sclk_i         (sclk_i),
      .csb_i          (csb_i),
      .sd_i           (sd_i),
      .sd_o           (sd_o),
      .sd_en_o        (sd_en_o),
      .tx_data_i      (tx_data_i),
      .tx_valid_i     (tx_valid_i),
      .tx_ready_o     (tx_ready_o),
      .rx_data_o      (rx_data_o),
      .rx_first_o     (rx_first_o),
      .rx_valid_o     (rx_valid_o),
      .rx_ready_i     (rx_ready_i),
      .rx_overflow_o  (rx_overflow_o),
      .tx_underflow_o (tx_underflow_o),
      .csb_deassert_o (csb_deassert_o)
   );

   int checks = 0;
   int failures = 0;

   int n_ready = 0, n_under = 0, n_ovf = 0, n_dea = 0, n_rx = 0;
   int x_ready = 0, x_under = 0, x_ovf = 0, x_dea = 0, x_rx = 0;

   logic [8:0] exp_rx[$];
   logic [7:0] host_b[8];
   logic       plan_v[8];
   logic [7:0] plan_d[8];
   int         tx_idx = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_tx();
      int i;
      i = (tx_idx > 7) ? 7 : tx_idx;
      tx_valid_i = plan_v[i];
      tx_data_i  = plan_d[i];
   endtask

   task automatic plan_rand();
      for (int i = 0; i < 8; i++) begin
         plan_v[i] = ($urandom_range(3, 0) != 0);
         plan_d[i] = 8'($urandom);
         host_b[i] = 8'($urandom);
      end
   endtask

   // one clock: monitor at negedge, return 1 time unit after posedge
   task automatic tick();
      logic adv;
      logic [8:0] item;
      @(negedge clk);
      adv = 1'b0;
      if (tx_ready_o) begin n_ready++; adv = 1'b1; end
      if (tx_underflow_o) begin n_under++; adv = 1'b1; end
      if (rx_overflow_o) n_ovf++;
      if (csb_deassert_o) n_dea++;
      if (rx_valid_o && rx_ready_i) begin
         n_rx++;
         if (exp_rx.size() != 0) begin
            item = exp_rx.pop_front();
            chk("rx_data", rx_data_o, item[7:0]);
            chk("rx_first", rx_first_o, item[8]);
         end
      end
      @(posedge clk);
      #1;
      if (adv) begin
         tx_idx++;
         drive_tx();
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_ready"}, n_ready, x_ready);
      chk({tag, "_under"}, n_under, x_under);
      chk({tag, "_ovf"}, n_ovf, x_ovf);
      chk({tag, "_dea"}, n_dea, x_dea);
      chk({tag, "_rxcnt"}, n_rx, x_rx);
   endtask

   task automatic run_txn(input int spd, input logic dr, input int nbytes,
                          input int extra, input logic hold);
      int bpe, epb, edges, sh, mask, xs, xe, loads;
      logic [7:0] xb;
      bpe  = (spd == 1) ? 2 : (spd == 2) ? 4 : 1;
      epb  = 8 / bpe;
      mask = (1 << bpe) - 1;
      speed_i    = 2'(spd);
      dir_i      = dr;
      rx_ready_i = !hold;
      tx_idx     = 0;
      drive_tx();
      if (spd != 3) begin
         loads = nbytes + 1;
         for (int i = 0; i < loads; i++)
            if (plan_v[i]) x_ready++; else x_under++;
         if (!hold) begin
            for (int i = 0; i < nbytes; i++)
               exp_rx.push_back({(i == 0), host_b[i]});
            x_rx += nbytes;
         end else if (nbytes > 1) begin
            x_ovf += nbytes - 1;
         end
      end
      x_dea++;
      csb_i = 1'b0;
      tick();
      tick();
      for (int b = 0; b <= nbytes; b++) begin
         edges = (b < nbytes) ? epb : extra;
         for (int e = 0; e < edges; e++) begin
            sh = 8 - bpe * (e + 1);
            xb = plan_v[b] ? plan_d[b] : IDLE;
            xs = (int'(xb) >> sh) & mask;
            if (spd == 0) xs = xs << 1;
            if (spd == 3) xs = 0;
            if (spd == 0) xe = 2;
            else if (spd == 3 || !dr) xe = 0;
            else xe = (spd == 1) ? 3 : 15;
            chk("sd_o", sd_o, xs);
            chk("sd_en_o", sd_en_o, xe);
            sd_i = 4'((int'(host_b[b]) >> sh) & mask);
            if (spd == 0) sd_i = sd_i | (4'($urandom) & 4'hE);
            if (spd == 1) sd_i = sd_i | (4'($urandom) & 4'hC);
            sclk_i = 1'b1;
            tick();
            tick();
            sclk_i = 1'b0;
            tick();
            tick();
         end
      end
      tick();
      tick();
      csb_i = 1'b1;
      sd_i  = 4'h0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      int spd, epb, nb, ex;
      plan_rand();
      rst_i = 1'b1;
      repeat (3) tick();
      chk("rst_sd_o", sd_o, 0);
      chk("rst_sd_en", sd_en_o, 0);
      chk("rst_rx_data", rx_data_o, 0);
      chk("rst_rx_valid", rx_valid_o, 0);
      chk("rst_rx_first", rx_first_o, 0);
      chk("rst_tx_ready", tx_ready_o, 0);
      chk("rst_ovf", rx_overflow_o, 0);
      chk("rst_under", tx_underflow_o, 0);
      chk("rst_dea", csb_deassert_o, 0);
      rst_i = 1'b0;
      tick();
      tick();

      // standard: TX A5 while host sends 3C
      plan_rand();
      plan_v[0] = 1'b1;
      plan_d[0] = 8'hA5;
      host_b[0] = 8'h3C;
      run_txn(0, 1'b0, 1, 0, 1'b0);
      chk_counts("std");

      // quad receive D2
      plan_rand();
      host_b[0] = 8'hD2;
      run_txn(2, 1'b0, 1, 0, 1'b0);
      chk_counts("quad");

      // overflow with a stalled consumer
      plan_rand();
      host_b[0] = 8'h11;
      host_b[1] = 8'h22;
      run_txn(0, 1'b0, 2, 0, 1'b1);
      chk("hold_valid", rx_valid_o, 1);
      chk("hold_data", rx_data_o, 8'h11);
      chk("hold_first", rx_first_o, 1);
      exp_rx.push_back({1'b1, 8'h11});
      x_rx++;
      rx_ready_i = 1'b1;
      tick();
      tick();
      chk_counts("ovf");

      // underflow: idle byte driven
      plan_rand();
      plan_v[0] = 1'b0;
      run_txn(0, 1'b0, 1, 0, 1'b0);
      chk_counts("under");

      // early deassert after 5 bits, then a normal byte
      plan_rand();
      run_txn(0, 1'b0, 0, 5, 1'b0);
      chk_counts("part");
      plan_rand();
      run_txn(0, 1'b0, 1, 0, 1'b0);
      chk_counts("after_part");

      // reserved lane mode does nothing but track csb
      plan_rand();
      run_txn(3, 1'b1, 1, 0, 1'b0);
      chk_counts("rsvd");

      // software reset mid-byte in dual
      plan_rand();
      plan_v[0]  = 1'b1;
      x_ready++;
      speed_i    = 2'd1;
      dir_i      = 1'b1;
      tx_idx     = 0;
      drive_tx();
      csb_i = 1'b0;
      tick();
      tick();
      for (int e = 0; e < 3; e++) begin
         sd_i   = 4'($urandom);
         sclk_i = 1'b1;
         tick();
         tick();
         sclk_i = 1'b0;
         tick();
         tick();
      end
      sw_rst_i = 1'b1;
      tick();
      chk("swr_sd_o", sd_o, 0);
      chk("swr_sd_en", sd_en_o, 0);
      chk("swr_rx_data", rx_data_o, 0);
      chk("swr_rx_valid", rx_valid_o, 0);
      chk("swr_tx_ready", tx_ready_o, 0);
      sw_rst_i = 1'b0;
      tick();
      tick();
      chk("swr_idle_en", sd_en_o, 0);
      chk("swr_idle_ready", tx_ready_o, 0);
      csb_i = 1'b1;
      tick();
      tick();
      tick();
      chk_counts("swr");
      plan_rand();
      host_b[0] = 8'h5A;
      run_txn(1, 1'b0, 1, 0, 1'b0);
      chk_counts("swr_next");

      // random transactions
      for (int t = 0; t < 24; t++) begin
         plan_rand();
         spd = $urandom_range(2, 0);
         epb = (spd == 1) ? 4 : (spd == 2) ? 2 : 8;
         nb  = $urandom_range(3, 1);
         ex  = ($urandom_range(3, 0) == 0) ? $urandom_range(epb - 1, 1) : 0;
         run_txn(spd, 1'($urandom), nb, ex, 1'b0);
         chk_counts("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
